// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the non-pipelined MIPS core: req/ack memory handshake,
// 2-bit PC source, illegal-opcode flagging, retired counter. Optional: MEM_TIMEOUT_EN.
module multicycle_ctrl #(
  parameter int INSTR_W     = 32,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [INSTR_W-1:0] Instr,
  input  logic               Zero,
  input  logic               MEM_Ack,
  output logic               MEM_Req,
  output logic               MEM_WrEn,
  output logic               IR_LdEn,
  output logic               PC_LdEn,
  output logic [1:0]         PC_sel,
  output logic               RF_WrEn,
  output logic               RF_WrData_sel,
  output logic               RF_B_sel,
  output logic               ALU_Bin_sel,
  output logic [3:0]         ALU_func,
  output logic               Illegal,
  output logic               Fault,
  output logic [CNT_W-1:0]   Retired
);

  typedef enum logic [2:0] {S_RST, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
  typedef enum logic [2:0] {C_R, C_ADDI, C_LW, C_SW, C_BEQ, C_J, C_ILL} iclass_t;

  state_t     state_q, state_d;
  iclass_t    iclass;
  logic [3:0] r_func;
  logic       retire;
  logic       timeout_hit;

  logic [5:0] opcode, funct;
  assign opcode = Instr[INSTR_W-1 -: 6];
  assign funct  = Instr[5:0];

  // Register/immediate fields are consumed by the datapath, not here.
  logic unused_fields;
  assign unused_fields = ^Instr[INSTR_W-7:6];

  // Instruction classification; Instr is held stable until retirement, so it is
  // decoded continuously rather than latched.
  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    iclass = C_ILL;
    r_func = 4'b0000;
    case (opcode)
      6'h00: begin
        iclass = C_R;
        case (funct)
          6'h20:   r_func = 4'b0000;
          6'h22:   r_func = 4'b0001;
          6'h24:   r_func = 4'b0010;
          6'h25:   r_func = 4'b0011;
          6'h2A:   r_func = 4'b0100;
          default: iclass = C_ILL;
        endcase
      end
      6'h08:   iclass = C_ADDI;
      6'h23:   iclass = C_LW;
      6'h2B:   iclass = C_SW;
      6'h04:   iclass = C_BEQ;
      6'h02:   iclass = C_J;
      default: iclass = C_ILL;
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);
  logic [WAIT_W-1:0] wait_cnt;
  logic              fault_q;

  // Any cycle outside a stalled request (including the ack cycle) clears the count,
  // which covers every entry into FETCH or MEM.
  always_ff @(posedge Clk) begin
    if (!Reset)
      wait_cnt <= '0;
    else if ((state_q == S_FETCH || state_q == S_MEM) && !MEM_Ack)
      wait_cnt <= wait_cnt + 1'b1;
    else
      wait_cnt <= '0;
  end

  assign timeout_hit = (state_q == S_FETCH || state_q == S_MEM) && !MEM_Ack &&
                       (wait_cnt == WAIT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge Clk) begin
    if (!Reset)           fault_q <= 1'b0;
    else if (timeout_hit) fault_q <= 1'b1;
  end
  assign Fault = fault_q;
`else
  localparam int unused_timeout = TIMEOUT_CYC;
  assign timeout_hit = 1'b0;
  assign Fault       = 1'b0;
`endif

  // NOTE: synchronous reset lives inside the clocked block; state uses <= only.
  always_ff @(posedge Clk) begin
    if (!Reset) state_q <= S_RST;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      S_RST:    state_d = S_FETCH;
      S_FETCH:  if (MEM_Ack) state_d = S_DECODE;
      S_DECODE: state_d = (iclass == C_ILL) ? S_FETCH : S_EXEC;
      S_EXEC: begin
        case (iclass)
          C_R, C_ADDI: state_d = S_WB;
          C_LW, C_SW:  state_d = S_MEM;
          default: begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end
        endcase
      end
      S_MEM: begin
        if (MEM_Ack) begin
          if (iclass == C_LW) state_d = S_WB;
          else begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end
        end
      end
      S_WB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RST;
    endcase
    if (timeout_hit) begin
      state_d = S_HALT;
      retire  = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset)      Retired <= '0;
    else if (retire) Retired <= Retired + 1'b1;
  end

  always_comb begin
    MEM_Req       = 1'b0;
    MEM_WrEn      = 1'b0;
    IR_LdEn       = 1'b0;
    PC_LdEn       = 1'b0;
    PC_sel        = 2'b00;
    RF_WrEn       = 1'b0;
    RF_WrData_sel = 1'b0;
    RF_B_sel      = 1'b0;
    ALU_Bin_sel   = 1'b0;
    ALU_func      = 4'b0000;
    Illegal       = 1'b0;
    case (state_q)
      S_FETCH: begin
        MEM_Req = 1'b1;
        if (MEM_Ack) begin
          IR_LdEn = 1'b1;
          PC_LdEn = 1'b1;
        end
      end
      S_DECODE: Illegal = (iclass == C_ILL);
      S_EXEC: begin
        case (iclass)
          C_R:              ALU_func = r_func;
          C_ADDI, C_LW, C_SW: ALU_Bin_sel = 1'b1;
          C_BEQ: begin
            ALU_func = 4'b0001;
            if (Zero) begin
              PC_LdEn = 1'b1;
              PC_sel  = 2'b01;
            end
          end
          C_J: begin
            PC_LdEn = 1'b1;
            PC_sel  = 2'b10;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        MEM_Req  = 1'b1;
        MEM_WrEn = (iclass == C_SW);
      end
      S_WB: begin
        RF_WrEn       = 1'b1;
        RF_WrData_sel = (iclass == C_LW);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle expected control vectors and Retired
// values go through a scoreboard queue and are checked on the falling edge.
module tb_multicycle_ctrl;
  localparam int CNT_W       = 4;
  localparam int TIMEOUT_CYC = 4;

  logic             Clk, Reset, Zero, MEM_Ack;
  logic [31:0]      Instr;
  logic             MEM_Req, MEM_WrEn, IR_LdEn, PC_LdEn, RF_WrEn, RF_WrData_sel;
  logic             RF_B_sel, ALU_Bin_sel, Illegal, Fault;
  logic [1:0]       PC_sel;
  logic [3:0]       ALU_func;
  logic [CNT_W-1:0] Retired;

  multicycle_ctrl #(.INSTR_W(32), .CNT_W(CNT_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .Clk(Clk), .Reset(Reset), .Instr(Instr), .Zero(Zero), .MEM_Ack(MEM_Ack),
    .MEM_Req(MEM_Req), .MEM_WrEn(MEM_WrEn), .IR_LdEn(IR_LdEn), .PC_LdEn(PC_LdEn),
    .PC_sel(PC_sel), .RF_WrEn(RF_WrEn), .RF_WrData_sel(RF_WrData_sel),
    .RF_B_sel(RF_B_sel), .ALU_Bin_sel(ALU_Bin_sel), .ALU_func(ALU_func),
    .Illegal(Illegal), .Fault(Fault), .Retired(Retired)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [15:0]      ctl;
    logic [CNT_W-1:0] ret;
    string            tag;
  } exp_t;

  exp_t             sb[$];
  int               errors = 0;
  int               checks = 0;
  logic [CNT_W-1:0] exp_ret = '0;

  // {Req, WrEn, IR_LdEn, PC_LdEn, PC_sel, RF_WrEn, RF_WrData_sel, RF_B_sel, ALU_Bin_sel, ALU_func, Illegal, Fault}
  function automatic logic [15:0] ctl(logic req, logic wr, logic ir, logic pcld, logic [1:0] sel,
                                      logic rfwr, logic rfd, logic alusel, logic [3:0] fn,
                                      logic ill, logic flt);
    return {req, wr, ir, pcld, sel, rfwr, rfd, 1'b0, alusel, fn, ill, flt};
  endfunction

  localparam logic [15:0] NONE  = 16'h0000;
  logic [15:0] f_wait, f_ack, ex_imm, wb_alu;
  initial begin
    f_wait = ctl(1, 0, 0, 0, 2'b00, 0, 0, 0, 4'h0, 0, 0);
    f_ack  = ctl(1, 0, 1, 1, 2'b00, 0, 0, 0, 4'h0, 0, 0);
    ex_imm = ctl(0, 0, 0, 0, 2'b00, 0, 0, 1, 4'h0, 0, 0);
    wb_alu = ctl(0, 0, 0, 0, 2'b00, 1, 0, 0, 4'h0, 0, 0);
  end

  task automatic step(input logic ack, input logic zero, input logic [15:0] ectl, input string tag);
    exp_t e;
    logic [15:0] obs;
    MEM_Ack = ack;
    Zero    = zero;
    sb.push_back('{ctl: ectl, ret: exp_ret, tag: tag});
    @(negedge Clk);
    e   = sb.pop_front();
    obs = {MEM_Req, MEM_WrEn, IR_LdEn, PC_LdEn, PC_sel, RF_WrEn, RF_WrData_sel,
           RF_B_sel, ALU_Bin_sel, ALU_func, Illegal, Fault};
    checks++;
    assert (obs === e.ctl) else begin
      errors++;
      $error("FAIL %s ctl observed=%h expected=%h", e.tag, obs, e.ctl);
    end
    checks++;
    assert (Retired === e.ret) else begin
      errors++;
      $error("FAIL %s retired observed=%0d expected=%0d", e.tag, Retired, e.ret);
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic run_r(input logic [31:0] ins, input logic [3:0] fn, input string tag);
    Instr = ins;
    step(1, 0, f_ack, {tag, "_fetch"});
    step(1, 0, NONE, {tag, "_decode_ack_ignored"});
    step(0, 0, ctl(0, 0, 0, 0, 2'b00, 0, 0, 0, fn, 0, 0), {tag, "_exec"});
    step(0, 0, wb_alu, {tag, "_wb"});
    exp_ret++;
  endtask

  task automatic run_j(input string tag);
    Instr = 32'h0800_0010;
    step(1, 0, f_ack, {tag, "_fetch"});
    step(0, 0, NONE, {tag, "_decode"});
    step(0, 0, ctl(0, 0, 0, 1, 2'b10, 0, 0, 0, 4'h0, 0, 0), {tag, "_exec"});
    exp_ret++;
  endtask

  initial begin
    Reset = 1'b0; Instr = '0; MEM_Ack = 1'b0; Zero = 1'b0;
    @(posedge Clk); #1;
    step(0, 0, NONE, "reset");
    step(1, 0, NONE, "reset_ack_ignored");
    Reset = 1'b1;
    step(0, 0, NONE, "reset_release");

    run_r(32'h0022_1820, 4'b0000, "add");
    run_r(32'h0022_1822, 4'b0001, "sub");
    run_r(32'h0022_1824, 4'b0010, "and");
    run_r(32'h0022_1825, 4'b0011, "or");
    run_r(32'h0022_182A, 4'b0100, "slt");

    Instr = 32'h2022_0005;
    step(1, 0, f_ack, "addi_fetch");
    step(0, 0, NONE, "addi_decode");
    step(0, 0, ex_imm, "addi_exec");
    step(0, 0, wb_alu, "addi_wb");
    exp_ret++;

    // lw: fetch ack after two waits, data ack after one wait, 8 cycles total.
    Instr = 32'h8C22_0004;
    step(0, 0, f_wait, "lw_fetch_w0");
    step(0, 0, f_wait, "lw_fetch_w1");
    step(1, 0, f_ack, "lw_fetch_ack");
    step(0, 0, NONE, "lw_decode");
    step(0, 0, ex_imm, "lw_exec");
    step(0, 0, ctl(1, 0, 0, 0, 2'b00, 0, 0, 0, 4'h0, 0, 0), "lw_mem_w0");
    step(1, 0, ctl(1, 0, 0, 0, 2'b00, 0, 0, 0, 4'h0, 0, 0), "lw_mem_ack");
    step(0, 0, ctl(0, 0, 0, 0, 2'b00, 1, 1, 0, 4'h0, 0, 0), "lw_wb");
    exp_ret++;

    Instr = 32'hAC22_0004;
    step(1, 0, f_ack, "sw_fetch");
    step(0, 0, NONE, "sw_decode");
    step(0, 0, ex_imm, "sw_exec");
    step(1, 0, ctl(1, 1, 0, 0, 2'b00, 0, 0, 0, 4'h0, 0, 0), "sw_mem_ack");
    exp_ret++;

    Instr = 32'h1022_0003;
    step(1, 0, f_ack, "beq_t_fetch");
    step(0, 1, NONE, "beq_t_decode");
    step(0, 1, ctl(0, 0, 0, 1, 2'b01, 0, 0, 0, 4'b0001, 0, 0), "beq_t_exec");
    exp_ret++;
    step(1, 0, f_ack, "beq_nt_fetch");
    step(0, 0, NONE, "beq_nt_decode");
    step(0, 0, ctl(0, 0, 0, 0, 2'b00, 0, 0, 0, 4'b0001, 0, 0), "beq_nt_exec");
    exp_ret++;

    Instr = 32'hFC00_0000;
    step(1, 0, f_ack, "ill_fetch");
    step(0, 0, ctl(0, 0, 0, 0, 2'b00, 0, 0, 0, 4'h0, 1, 0), "ill_decode");
    Instr = 32'h0022_1830;
    step(1, 0, f_ack, "ill_back_to_fetch");
    step(0, 0, ctl(0, 0, 0, 0, 2'b00, 0, 0, 0, 4'h0, 1, 0), "ill_funct_decode");

    for (int i = 0; i < 18; i++) run_j($sformatf("j%0d", i));

    // Reset asserted while sw holds MEM_Req.
    Instr = 32'hAC22_0004;
    step(1, 0, f_ack, "sw2_fetch");
    step(0, 0, NONE, "sw2_decode");
    step(0, 0, ex_imm, "sw2_exec");
    step(0, 0, ctl(1, 1, 0, 0, 2'b00, 0, 0, 0, 4'h0, 0, 0), "sw2_mem_wait");
    Reset = 1'b0;
    step(0, 0, ctl(1, 1, 0, 0, 2'b00, 0, 0, 0, 4'h0, 0, 0), "sw2_mem_reset_edge");
    exp_ret = '0;
    step(1, 0, NONE, "mid_reset_state");
    Reset = 1'b1;
    step(1, 0, NONE, "mid_reset_release");
    run_j("j_after_reset");

`ifdef MEM_TIMEOUT_EN
    Reset = 1'b0;
    step(0, 0, ctl(1, 0, 0, 0, 2'b00, 0, 0, 0, 4'h0, 0, 0), "to_reset_edge");
    exp_ret = '0;
    Reset = 1'b1;
    step(0, 0, NONE, "to_rst");
    for (int i = 0; i < TIMEOUT_CYC; i++) step(0, 0, f_wait, $sformatf("to_wait%0d", i));
    for (int i = 0; i < 3; i++)
      step(1, 0, ctl(0, 0, 0, 0, 2'b00, 0, 0, 0, 4'h0, 0, 1), $sformatf("to_halt%0d", i));
    Reset = 1'b0;
    step(0, 0, ctl(0, 0, 0, 0, 2'b00, 0, 0, 0, 4'h0, 0, 1), "to_halt_reset_edge");
    step(0, 0, NONE, "to_fault_cleared");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
